mux_n_interleaver: RTL and testbench
====================================

MUX_N_INTERLEAVER -- requirements
Module: mux_n_interleaver

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of input channels, legal range 2..8, non-power-of-two allowed.
REQ-002 The block SHALL have parameter WIDTH, default 8: data width per channel.
REQ-003 The block SHALL have port clk8f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, NUM_CH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 The block SHALL have port valid_in, input, NUM_CH bits: bit k qualifies channel k.
REQ-007 The block SHALL have port ch_mask, input, NUM_CH bits: bit k=1 enables channel k; a masked channel is treated as invalid at capture.
REQ-008 The block SHALL have port sample_req, output, 1 bit: combinational; high in the cycle whose closing edge captures the inputs.
REQ-009 The block SHALL have port data_out, output, WIDTH bits: registered serial data.
REQ-010 The block SHALL have port valid_out, output, 1 bit: registered qualifier for data_out.
REQ-011 The block SHALL have port frame_sync, output, 1 bit: registered; high while the slot-0 output is presented.

Function
REQ-012 A slot counter cnt, width $clog2(NUM_CH), SHALL increment on every edge and wrap from NUM_CH-1 to 0.
REQ-013 sample_req SHALL be 1 exactly when cnt==NUM_CH-1.
REQ-014 On an edge with cnt==NUM_CH-1, a holding bank SHALL load data_in and bank_v SHALL load valid_in & ch_mask; otherwise the bank SHALL hold.
REQ-015 On every edge, valid_out SHALL load bank_v[cnt]; data_out SHALL load bank[cnt] if bank_v[cnt]=1 and otherwise SHALL hold its previous value. Both use the pre-edge bank and cnt.
REQ-016 On every edge, frame_sync SHALL load (cnt==0).
REQ-017 Latency: inputs captured at edge E SHALL appear for channel k at edge E+1+k, in ascending channel order, one channel per cycle.
REQ-018 Inputs SHALL be ignored on all edges other than capture edges; changes between captures have no effect.
REQ-019 At the capture edge, channel NUM_CH-1 of the old bank SHALL be output while the bank is reloaded; no slot is lost or duplicated.
REQ-020 With all channels masked or invalid, valid_out SHALL stay 0 for the whole frame, and data_out SHALL hold.

Reset
REQ-021 While reset=1, cnt, bank, bank_v, data_out, valid_out and frame_sync SHALL be 0 immediately, independent of clk8f.
REQ-022 After reset deasserts, the first edge SHALL produce frame_sync=1 and valid_out=0; the first capture SHALL occur at the NUM_CH-th edge.
REQ-023 Reset asserted mid-frame SHALL discard the bank contents; no partial frame is output after release.

Configuration
REQ-024 With macro MUX_N_INTERLEAVER_CH_TAG_EN defined, an output ch_out ($clog2(NUM_CH) bits) SHALL exist. It SHALL be registered, load cnt on every edge alongside data_out, and reset to 0.
REQ-025 Without MUX_N_INTERLEAVER_CH_TAG_EN, ch_out SHALL NOT exist and behaviour is otherwise identical.

Verification (NUM_CH=4, WIDTH=8)
REQ-026 Reset release scenario:
- stimulus: release reset; data_in=0x44_33_22_11, valid_in=4'hF, ch_mask=4'hF;
- required response: edges 1-4 give valid_out=0, frame_sync=1 at edge 1, sample_req=1 before edge 4; edges 5-8 give data_out 0x11, 0x22, 0x33, 0x44 with valid_out=1.
REQ-027 Channel-invalid scenario:
- stimulus: valid_in=4'b1010 at capture;
- required response: slots 0 and 2 give valid_out=0 with data_out holding the prior value; slots 1 and 3 give valid_out=1 with correct data.
REQ-028 Mask scenario:
- stimulus: ch_mask=4'b0001, valid_in=4'hF;
- required response: only slot 0 is valid in each frame.
REQ-029 Input-ignored scenario:
- stimulus: toggle data_in on non-capture cycles;
- required response: the output frame equals the values present at the capture edge only.
REQ-030 Asynchronous reset scenario:
- stimulus: assert reset between edges mid-frame;
- required response: outputs become 0 before the next edge; the post-release sequence matches REQ-026.
REQ-031 Channel-tag scenario:
- stimulus: build with MUX_N_INTERLEAVER_CH_TAG_EN defined;
- required response: ch_out runs 0, 1, 2, 3 cyclically, aligned with data_out, with ch_out=0 whenever frame_sync=1.

Source files
------------

// File: rtl/mux_n_interleaver_if.sv
// mux_n_interleaver_if: parallel capture inputs and serial interleaved outputs of mux_n_interleaver
// ch_out is present only when MUX_N_INTERLEAVER_CH_TAG_EN is defined
interface mux_n_interleaver_if #(parameter int NUM_CH = 4, parameter int WIDTH = 8);
  logic [NUM_CH*WIDTH-1:0] data_in;
  logic [NUM_CH-1:0] valid_in;
  logic [NUM_CH-1:0] ch_mask;
  logic sample_req;
  logic [WIDTH-1:0] data_out;
  logic valid_out;
  logic frame_sync;
`ifdef MUX_N_INTERLEAVER_CH_TAG_EN
  logic [$clog2(NUM_CH)-1:0] ch_out;
  modport master (output data_in, valid_in, ch_mask, input sample_req, data_out, valid_out, frame_sync, ch_out);
  modport slave (input data_in, valid_in, ch_mask, output sample_req, data_out, valid_out, frame_sync, ch_out);
`else
  modport master (output data_in, valid_in, ch_mask, input sample_req, data_out, valid_out, frame_sync);
  modport slave (input data_in, valid_in, ch_mask, output sample_req, data_out, valid_out, frame_sync);
`endif
endinterface

// File: rtl/mux_n_interleaver.sv
// mux_n_interleaver: captures NUM_CH channels once per frame and serialises them one slot per cycle.
// Defining MUX_N_INTERLEAVER_CH_TAG_EN adds a registered ch_out slot tag.
module mux_n_interleaver #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 8
) (
  input logic clk8f,
  input logic reset,
  mux_n_interleaver_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);
  logic [CW-1:0] cnt;
  logic [NUM_CH-1:0][WIDTH-1:0] bank;
  logic [NUM_CH-1:0] bank_v;
  logic cap;
  assign cap = cnt == LAST;
  assign bus.sample_req = cap;
  // the last slot of the old bank is read with pre-edge values while the bank reloads
  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      bank <= '0;
      bank_v <= '0;
      bus.data_out <= '0;
      bus.valid_out <= 1'b0;
      bus.frame_sync <= 1'b0;
`ifdef MUX_N_INTERLEAVER_CH_TAG_EN
      bus.ch_out <= '0;
`endif
    end else begin
      cnt <= cap ? '0 : cnt + 1'b1;
      if (cap) begin
        bank <= bus.data_in;
        bank_v <= bus.valid_in & bus.ch_mask;
      end
      bus.valid_out <= bank_v[cnt];
      if (bank_v[cnt]) bus.data_out <= bank[cnt];
      bus.frame_sync <= cnt == '0;
`ifdef MUX_N_INTERLEAVER_CH_TAG_EN
      bus.ch_out <= cnt;
`endif
    end
  end
endmodule

// File: tb/tb_mux_n_interleaver.sv
// tb_mux_n_interleaver: directed and random frames checked against an edge-counting frame model.
module tb_mux_n_interleaver;
  localparam int N = 4;
  localparam int W = 8;
  logic clk8f = 1'b0;
  logic reset = 1'b1;
  mux_n_interleaver_if #(.NUM_CH(N), .WIDTH(W)) bus();
  mux_n_interleaver #(.NUM_CH(N), .WIDTH(W)) dut (.clk8f(clk8f), .reset(reset), .bus(bus));
  always #5 clk8f = ~clk8f;
  int n_chk = 0;
  int n_fail = 0;
  int n = 0;
  logic [W-1:0] m_bank [N];
  logic m_v [N];
  logic [W-1:0] exp_do;
  logic exp_vo, exp_fs;
  int exp_tag;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    n = 0;
    for (int k = 0; k < N; k++) begin
      m_bank[k] = '0;
      m_v[k] = 1'b0;
    end
    exp_do = '0;
    exp_vo = 1'b0;
    exp_fs = 1'b0;
    exp_tag = 0;
  endtask
  task automatic chk_out(input string tag);
    chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'(exp_vo));
    chk({tag, ".data_out"}, 32'(bus.data_out), 32'(exp_do));
    chk({tag, ".frame_sync"}, 32'(bus.frame_sync), 32'(exp_fs));
`ifdef MUX_N_INTERLEAVER_CH_TAG_EN
    chk({tag, ".ch_out"}, 32'(bus.ch_out), 32'(exp_tag));
    if (bus.frame_sync) chk({tag, ".ch_out_at_sync"}, 32'(bus.ch_out), 32'd0);
`endif
  endtask
  task automatic cycle(input string tag, input logic [N*W-1:0] din, input logic [N-1:0] vin, input logic [N-1:0] mask);
    int s;
    bus.data_in = din;
    bus.valid_in = vin;
    bus.ch_mask = mask;
    #1;
    chk({tag, ".sample_req"}, 32'(bus.sample_req), 32'((n % N) == N - 1));
    @(posedge clk8f);
    s = n % N;
    exp_vo = m_v[s];
    if (m_v[s]) exp_do = m_bank[s];
    exp_fs = s == 0;
    exp_tag = s;
    if (s == N - 1)
      for (int k = 0; k < N; k++) begin
        m_bank[k] = din[k*W +: W];
        m_v[k] = vin[k] & mask[k];
      end
    n++;
    #1;
    chk_out(tag);
  endtask
  initial begin
    logic [N*W-1:0] base;
    base = 32'h44332211;
    bus.data_in = '0;
    bus.valid_in = '0;
    bus.ch_mask = '0;
    model_reset();
    #2;
    chk_out("por");
    #10;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cycle("release", base, 4'hF, 4'hF);
    chk("release.last_data", 32'(bus.data_out), 32'h44);
    for (int i = 0; i < 8; i++) cycle("invalid", base ^ 32'h0F0F0F0F, 4'b1010, 4'hF);
    for (int i = 0; i < 8; i++) cycle("mask", base + 32'h01010101, 4'hF, 4'b0001);
    for (int i = 0; i < 8; i++) cycle("toggle", ((n % N) == N - 1) ? base : $urandom, 4'hF, 4'hF);
    for (int i = 0; i < 8; i++) cycle("all_off", $urandom, 4'h0, 4'hF);
    for (int i = 0; i < 40; i++) cycle("random", $urandom, N'($urandom), N'($urandom));
    for (int i = 0; i < 6; i++) cycle("prefill", 32'hA5C3E187, 4'hF, 4'hF);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk_out("async_reset");
    @(posedge clk8f);
    @(posedge clk8f);
    #3;
    chk_out("held_reset");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cycle("post_reset", base, 4'hF, 4'hF);
    chk("post_reset.last_data", 32'(bus.data_out), 32'h44);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
